// File: rtl/alu_operand_fetch_if.sv
// alu_operand_fetch_if: instruction intake, ALU operand and writeback bundle
// for the operand-fetch stage. The slave modport is the fetch stage itself;
// the master modport is the surrounding pipeline (upstream, ALU, writeback).
interface alu_operand_fetch_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  // Upstream instruction handshake
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;
  // Operands towards the ALU
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        opcode;
  logic [DATA_W-1:0] reg_rs1;
  logic [DATA_W-1:0] reg_rs2;
  logic [ADDR_W-1:0] rd_addr;
  // Writeback port
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output in_valid, instr, out_ready, wb_en, wb_addr, wb_data,
    input  in_ready, out_valid, opcode, reg_rs1, reg_rs2, rd_addr
  );

  modport slave (
    input  in_valid, instr, out_ready, wb_en, wb_addr, wb_data,
    output in_ready, out_valid, opcode, reg_rs1, reg_rs2, rd_addr
  );
endinterface

// File: rtl/alu_operand_fetch.sv
// alu_operand_fetch: decodes instructions, reads the register file, stalls on
// RAW hazards via a per-register pending scoreboard and registers operands for
// the ALU. Optional build macro OPFETCH_WB_BYPASS_EN forwards same-cycle
// writeback data into the read path and masks the matching pending bit.
module alu_operand_fetch #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32
) (
  input logic              clk,
  input logic              rst_n,
  alu_operand_fetch_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(NREGS);
  localparam int unsigned OPC_W  = 6;
  localparam int unsigned IMM_W  = 16;

  // Architectural state
  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  r_pending;

  // Output register towards the ALU
  logic              r_out_valid;
  logic [OPC_W-1:0]  r_opcode;
  logic [DATA_W-1:0] r_rs1_val;
  logic [DATA_W-1:0] r_rs2_val;
  logic [ADDR_W-1:0] r_rd_addr;

  // Decode
  logic [OPC_W-1:0]  w_opcode;
  logic [ADDR_W-1:0] w_rd;
  logic [ADDR_W-1:0] w_rs1;
  logic [ADDR_W-1:0] w_rs2;
  logic [IMM_W-1:0]  w_imm;
  logic              w_imm_form;

  logic              w_wb_hit;
  logic [NREGS-1:0]  w_pend_eff;
  logic [NREGS-1:0]  w_pending_nxt;
  logic [DATA_W-1:0] w_rs1_val;
  logic [DATA_W-1:0] w_rs2_val;
  logic [DATA_W-1:0] w_b_val;
  logic              w_hazard;
  logic              w_in_ready;
  logic              w_accept;

  assign w_opcode   = bus.instr[31:26];
  assign w_rd       = bus.instr[25:21];
  assign w_rs1      = bus.instr[20:16];
  assign w_rs2      = bus.instr[15:11];
  assign w_imm      = bus.instr[15:0];
  assign w_imm_form = w_opcode[4];

  // r0 is hardwired to zero, so writebacks to it are dropped everywhere
  assign w_wb_hit = bus.wb_en && (bus.wb_addr != '0);

`ifdef OPFETCH_WB_BYPASS_EN
  logic [NREGS-1:0] w_wb_mask;

  // One-hot of the register being written back this cycle
  always_comb begin
    w_wb_mask = '0;
    if (w_wb_hit) w_wb_mask[bus.wb_addr] = 1'b1;
  end

  // A register completing writeback this cycle is no longer a hazard
  always_comb begin
    w_pend_eff = r_pending & ~w_wb_mask;
  end

  // Register reads with same-cycle writeback forwarding
  always_comb begin
    w_rs1_val = '0;
    w_rs2_val = '0;
    if (w_rs1 != '0) w_rs1_val = r_regs[w_rs1];
    if (w_rs2 != '0) w_rs2_val = r_regs[w_rs2];
    if (w_wb_hit && (bus.wb_addr == w_rs1)) w_rs1_val = bus.wb_data;
    if (w_wb_hit && (bus.wb_addr == w_rs2)) w_rs2_val = bus.wb_data;
  end
`else
  // Without bypass the hazard check sees the raw pending bits
  always_comb begin
    w_pend_eff = r_pending;
  end

  // Register reads return the pre-write value
  always_comb begin
    w_rs1_val = '0;
    w_rs2_val = '0;
    if (w_rs1 != '0) w_rs1_val = r_regs[w_rs1];
    if (w_rs2 != '0) w_rs2_val = r_regs[w_rs2];
  end
`endif

  // Operand B: zero-extended immediate or rs2 value
  always_comb begin
    w_b_val = w_rs2_val;
    if (w_imm_form) w_b_val = DATA_W'(w_imm);
  end

  // RAW hazard: rs1 pending, or rs2 pending in register form
  always_comb begin
    w_hazard = w_pend_eff[w_rs1];
    if (!w_imm_form && w_pend_eff[w_rs2]) w_hazard = 1'b1;
  end

  assign w_in_ready = !w_hazard && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  // Scoreboard update; a set on accept wins over a same-register clear
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_wb_hit) w_pending_nxt[bus.wb_addr] = 1'b0;
    if (w_accept && (w_rd != '0)) w_pending_nxt[w_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  // Pending scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  // Register file write port; contents are cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= '0;
    end else if (w_wb_hit) begin
      r_regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Operand output register: load on accept, drop valid once consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_opcode    <= '0;
      r_rs1_val   <= '0;
      r_rs2_val   <= '0;
      r_rd_addr   <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_opcode    <= w_opcode;
      r_rs1_val   <= w_rs1_val;
      r_rs2_val   <= w_b_val;
      r_rd_addr   <= w_rd;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.opcode    = r_opcode;
  assign bus.reg_rs1   = r_rs1_val;
  assign bus.reg_rs2   = r_rs2_val;
  assign bus.rd_addr   = r_rd_addr;

endmodule
